alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//   Operand-fetch / writeback sequencer directly upstream and downstream of the 8-bit ALU.
//   - Accepts one 8-bit instruction per handshake.
//   - Reads two operands from a 4 x 8-bit register file and drives ALU op1/op2/sel.
//   - Captures the ALU result and carry, writes the result back to rd and updates the carry flag.
//   - Includes a load port to preset registers from the surrounding CPU.
// PARAMETERS
//   DW       8      data width; must equal ALU width (8)
//   RST_VAL  8'h00  reset value of every register-file entry
// PORTS
//   clk          in   1   single clock, all state on rising edge
//   rst_n        in   1   synchronous, active-low reset
//   instr_valid  in   1   instruction present
//   instr_ready  out  1   sequencer can accept (high only in IDLE)
//   instr        in   8   [7:5]=ALU sel, [4]=ignored, [3:2]=rd (also rs1), [1:0]=rs2
//   ld_en        in   1   register preset strobe
//   ld_addr      in   2   preset target
//   ld_data      in   DW  preset value
//   alu_op1      out  DW  to ALU op1 (registered)
//   alu_op2      out  DW  to ALU op2 (registered)
//   alu_sel      out  3   to ALU sel (registered)
//   alu_out      in   DW  ALU result (combinational from alu_op1/op2/sel)
//   alu_co       in   1   ALU carry
//   done         out  1   1-cycle pulse when writeback happens
//   carry_flag   out  1   sticky carry status
//   rd_sel       in   2   debug read address
//   rd_data      out  DW  regfile[rd_sel], combinational
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): FSM->IDLE; all regs=RST_VAL; alu_op1/op2=0; alu_sel=3'b101
//     (pass op1); done=0; carry_flag=0. Reset mid-instruction aborts it; no writeback.
//   - FSM IDLE -> READ -> EXEC -> WB -> IDLE:
//     IDLE: instr_ready=1; accept on instr_valid&instr_ready and latch instr.
//     READ: alu_op1<=reg[rd], alu_op2<=reg[rs2], alu_sel<=instr[7:5].
//     EXEC: ALU settles; result/carry sampled into internal res/co regs.
//     WB:   reg[rd]<=res, done=1. Update carry_flag<=co only for sel 000, 001, 011.
//           All other sels hold carry_flag (the ALU carry is undefined for them).
//   - Latency: accept at edge T, done high in cycle T+3, instr_ready high again at T+4.
//   - alu_op1/op2/sel hold their values outside READ. The ALU input must be stable EXEC..WB.
//   - rd==rs2 is legal: both operands read the same pre-writeback value.
//   - Load port is honoured in any state.
//     - ld to a register being read in the READ cycle: READ sees the old value.
//     - ld and WB to the same register in the same cycle: WB wins, ld dropped.
//     - ld and WB to different registers in the same cycle: both write.
//   - instr_valid while instr_ready=0 is ignored. The source must hold it; no queuing.
//   - Arithmetic is owned by the ALU. This block truncates nothing and adds no sign handling.
//     Result written = alu_out[DW-1:0].
// CONFIGURATION
//   SEQ_FAST_EN defined:
//     - EXEC state is removed: READ -> WB.
//     - WB samples alu_out/alu_co directly.
//     - done at T+2, instr_ready at T+3.
//   Not defined: 4-state FSM above (one full cycle of ALU settle margin).
// TESTING
//   1. Reset, no ld: rd_data for sel 0..3 = 8'h00, carry_flag=0, instr_ready=1, alu_sel=3'b101.
//   2. ld r1=8'hF0, r2=8'h20; instr 8'b000_0_01_10 (ADD r1,r2):
//      done at T+3, r1=8'h10, carry_flag=1, r2 unchanged.
//   3. After 2, instr 8'b010_0_01_01 (XNOR r1,r1): r1=8'hFF; carry_flag stays 1.
//   4. ld r3=8'h81; instr 8'b001_0_11_00 (ASHL r3): r3 = ALU result, carry_flag = ALU co.
//      During WB, ld_en to r3 with 8'h55: WB value kept, 8'h55 dropped.
//   5. Hold instr_valid high for 6 cycles with two back-to-back instrs:
//      exactly one accept per 4 cycles, done pulses exactly once each.
//   6. Deassert rst_n during EXEC: next cycle IDLE, done never pulses, rd register = RST_VAL.
//      Repeat 2 with SEQ_FAST_EN: done at T+2.

Source files
------------

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_seq
// Description : Operand-fetch / writeback sequencer wrapped around an 8-bit
//               ALU. Takes one instruction per handshake, reads two operands
//               from a 4-entry register file, drives the ALU, then writes the
//               result back to rd and updates the sticky carry flag.
//               Build option SEQ_FAST_EN removes the EXEC settle cycle, so
//               the flow becomes IDLE -> READ -> WB.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_seq #(
   parameter int              DW      = 8,
   parameter logic [DW-1:0]   RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [7:0]    instr,
   input  logic          ld_en,
   input  logic [1:0]    ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic [DW-1:0] alu_op1,
   output logic [DW-1:0] alu_op2,
   output logic [2:0]    alu_sel,
   input  logic [DW-1:0] alu_out,
   input  logic          alu_co,
   output logic          done,
   output logic          carry_flag,
   input  logic [1:0]    rd_sel,
   output logic [DW-1:0] rd_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t        state;
   logic [DW-1:0] regs [4];

   // Latched instruction fields; instr[4] carries no meaning.
   logic [2:0]    ir_sel;
   logic [1:0]    ir_rd;
   logic [1:0]    ir_rs2;
   logic          unused_instr_bit;

   // Value and carry that the WB cycle commits.
   logic [DW-1:0] wb_val;
   logic          wb_co;
   logic          carry_upd;

   assign unused_instr_bit = instr[4];

`ifdef SEQ_FAST_EN
   // No settle cycle: the ALU inputs were registered in READ, so its output
   // is already stable for the whole WB cycle and is committed directly.
   assign wb_val = alu_out;
   assign wb_co  = alu_co;
`else
   // Snapshot of the ALU taken at the end of the EXEC settle cycle.
   logic [DW-1:0] res;
   logic          co;

   assign wb_val = res;
   assign wb_co  = co;
`endif

   // Only ADD, ASHL and SUB-class selects produce a meaningful carry.
   assign carry_upd   = (ir_sel == 3'b000) || (ir_sel == 3'b001) || (ir_sel == 3'b011);
   assign instr_ready = (state == S_IDLE);
   assign rd_data     = regs[rd_sel];

   // Sequencer FSM, register file, ALU operand registers and status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ir_sel     <= 3'b000;
         ir_rd      <= 2'b00;
         ir_rs2     <= 2'b00;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_sel    <= 3'b101;
         done       <= 1'b0;
         carry_flag <= 1'b0;
`ifndef SEQ_FAST_EN
         res        <= '0;
         co         <= 1'b0;
`endif
         for (int i = 0; i < 4; i++) begin
            regs[i] <= RST_VAL;
         end
      end else begin
         done <= 1'b0;

         // Preset port works in every state; a writeback to the same entry
         // in the same cycle takes priority and the preset is dropped.
         if (ld_en && !((state == S_WB) && (ld_addr == ir_rd))) begin
            regs[ld_addr] <= ld_data;
         end

         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  ir_sel <= instr[7:5];
                  ir_rd  <= instr[3:2];
                  ir_rs2 <= instr[1:0];
                  state  <= S_READ;
               end
            end

            S_READ: begin
               // Non-blocking reads: a same-cycle preset is not yet visible.
               alu_op1 <= regs[ir_rd];
               alu_op2 <= regs[ir_rs2];
               alu_sel <= ir_sel;
`ifdef SEQ_FAST_EN
               done    <= 1'b1;
               state   <= S_WB;
`else
               state   <= S_EXEC;
`endif
            end

`ifndef SEQ_FAST_EN
            S_EXEC: begin
               res   <= alu_out;
               co    <= alu_co;
               done  <= 1'b1;
               state <= S_WB;
            end
`endif

            S_WB: begin
               regs[ir_rd] <= wb_val;
               if (carry_upd) begin
                  carry_flag <= wb_co;
               end
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_seq
// Description : Self-checking bench for alu_issue_seq. Provides a behavioural
//               8-bit ALU, keeps a transaction-level reference model of the
//               register file / carry / handshake timing, and compares the DUT
//               against it every cycle. Honours SEQ_FAST_EN for latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_seq;

   localparam int DW = 8;
`ifdef SEQ_FAST_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid;
   logic          instr_ready;
   logic [7:0]    instr;
   logic          ld_en;
   logic [1:0]    ld_addr;
   logic [DW-1:0] ld_data;
   logic [DW-1:0] alu_op1, alu_op2, alu_out;
   logic [2:0]    alu_sel;
   logic          alu_co;
   logic          done;
   logic          carry_flag;
   logic [1:0]    rd_sel = 2'd0;
   logic [DW-1:0] rd_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_issue_seq #(.DW(DW), .RST_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_co(alu_co),
      .done(done), .carry_flag(carry_flag),
      .rd_sel(rd_sel), .rd_data(rd_data)
   );

   // Behavioural ALU: returns {carry, result}. Carry for non-arithmetic
   // selects is deliberately junk so a wrongly-updated flag shows up.
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s);
      case (s)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {a[7], a[6:0], 1'b0};
         3'd2:    return {a[0], ~(a ^ b)};
         3'd3:    return {1'b0, a} - {1'b0, b};
         3'd4:    return {b[7], a & b};
         3'd5:    return {a[3], a};
         3'd6:    return {a[1] ^ b[2], a | b};
         default: return {b[0], a ^ b};
      endcase
   endfunction

   always_comb {alu_co, alu_out} = alu_f(alu_op1, alu_op2, alu_sel);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // m_age: 0 = idle, k = k-th cycle after the accept edge; writeback on LAT.
   logic [7:0] m_reg [4];
   logic       m_carry;
   int         m_age;
   logic [7:0] m_ir;
   logic [7:0] m_op1, m_op2;
   logic [2:0] m_sel;
   logic       m_valid = 1'b0;

   always @(posedge clk) begin
      logic [8:0] r;
      logic [1:0] rd;
      logic       wb;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
         m_carry = 1'b0;
         m_age   = 0;
         m_ir    = 8'h00;
         m_op1   = 8'h00;
         m_op2   = 8'h00;
         m_sel   = 3'b101;
         m_valid = 1'b1;
      end else if (m_valid) begin
         rd = m_ir[3:2];
         wb = (m_age == LAT);
         if (m_age == 1) begin
            m_op1 = m_reg[m_ir[3:2]];
            m_op2 = m_reg[m_ir[1:0]];
            m_sel = m_ir[7:5];
         end
         if (ld_en && !(wb && ld_addr == rd)) m_reg[ld_addr] = ld_data;
         if (wb) begin
            r = alu_f(m_op1, m_op2, m_sel);
            m_reg[rd] = r[7:0];
            if (m_sel inside {3'd0, 3'd1, 3'd3}) m_carry = r[8];
            m_age = 0;
         end else if (m_age > 0) begin
            m_age++;
         end else if (instr_valid) begin
            m_ir  = instr;
            m_age = 1;
         end
      end
   end

   // Compare process: every cycle, DUT outputs against the model.
   always @(negedge clk) begin
      rd_sel = rd_sel + 2'd1;
      #1;
      if (m_valid) begin
         check("instr_ready", {31'd0, instr_ready}, {31'd0, m_age == 0});
         check("done",        {31'd0, done},        {31'd0, m_age == LAT});
         check("carry_flag",  {31'd0, carry_flag},  {31'd0, m_carry});
         check("alu_op1",     {24'd0, alu_op1},     {24'd0, m_op1});
         check("alu_op2",     {24'd0, alu_op2},     {24'd0, m_op2});
         check("alu_sel",     {29'd0, alu_sel},     {29'd0, m_sel});
         check("rd_data",     {24'd0, rd_data},     {24'd0, m_reg[rd_sel]});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
   endtask

   // Issue one instruction, measure accept-to-done latency, optionally
   // preset a register during the WB cycle, then wait for idle.
   task automatic send(input logic [7:0] i, input logic wb_ld,
                       input logic [1:0] la, input logic [7:0] ld);
      int lat;
      int k;
      instr = i;
      instr_valid = 1'b1;
      k = 0;
      while (!instr_ready && k < 20) begin tick(); k++; end
      if (!instr_ready) begin
         fail_timeout("accept");
         instr_valid = 1'b0;
         return;
      end
      tick();
      instr_valid = 1'b0;
      lat = 1;
      while (!done && lat < 12) begin tick(); lat++; end
      check("latency", lat, LAT);
      if (wb_ld) begin
         ld_en = 1'b1; ld_addr = la; ld_data = ld;
      end
      tick();
      ld_en = 1'b0;
      k = 0;
      while (!instr_ready && k < 20) begin tick(); k++; end
      if (!instr_ready) fail_timeout("return_idle");
   endtask

   initial begin
      int acc, dn, first_acc, second_acc, seen_done;
      logic rdy;
      rst_n = 1'b0; instr_valid = 1'b0; instr = 8'h00;
      ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00;
      repeat (2) tick();
      rst_n = 1'b1;

      // 1. reset state
      check("rst_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_sel",   {29'd0, alu_sel},     32'd5);
      check("rst_carry", {31'd0, carry_flag},  32'd0);
      for (int i = 0; i < 4; i++) check("rst_model_reg", {24'd0, m_reg[i]}, 32'd0);

      // 2. ADD r1,r2 with r1=F0, r2=20
      load(2'd1, 8'hF0);
      load(2'd2, 8'h20);
      send(8'b000_0_01_10, 1'b0, 2'd0, 8'h00);
      check("add_r1",    {24'd0, m_reg[1]}, 32'h10);
      check("add_r2",    {24'd0, m_reg[2]}, 32'h20);
      check("add_carry", {31'd0, m_carry},  32'd1);

      // 3. XNOR r1,r1: all ones, carry held
      send(8'b010_0_01_01, 1'b0, 2'd0, 8'h00);
      check("xnor_r1",    {24'd0, m_reg[1]}, 32'hFF);
      check("xnor_carry", {31'd0, m_carry},  32'd1);

      // 4. ASHL r3 with r3=81; preset of r3 during WB is dropped
      load(2'd3, 8'h81);
      send(8'b001_0_11_00, 1'b1, 2'd3, 8'h55);
      check("ashl_r3",    {24'd0, m_reg[3]}, 32'h02);
      check("ashl_carry", {31'd0, m_carry},  32'd1);

      // 5. valid held high over two back-to-back instructions
      instr = 8'b110_0_10_11;
      instr_valid = 1'b1;
      acc = 0; dn = 0; first_acc = -1; second_acc = -1;
      for (int c = 0; c < 12; c++) begin
         rdy = instr_ready && instr_valid;
         tick();
         if (rdy) begin
            acc++;
            if (acc == 1) begin first_acc = c; instr = 8'b011_0_00_01; end
            else begin second_acc = c; instr_valid = 1'b0; end
         end
         if (done) dn++;
      end
      instr_valid = 1'b0;
      check("b2b_accepts", acc, 2);
      check("b2b_dones",   dn, 2);
      check("b2b_period",  second_acc - first_acc, LAT + 1);

      // 6. reset while an instruction is in flight
      load(2'd0, 8'h33);
      instr = 8'b000_0_00_00;
      instr_valid = 1'b1;
      while (!instr_ready) tick();
      tick();
      instr_valid = 1'b0;
      repeat (LAT - 2) tick();
      seen_done = 0;
      rst_n = 1'b0;
      if (done) seen_done++;
      tick();
      rst_n = 1'b1;
      check("abort_ready", {31'd0, instr_ready}, 32'd1);
      for (int c = 0; c < 6; c++) begin
         if (done) seen_done++;
         tick();
      end
      check("abort_no_done", seen_done, 0);
      check("abort_r0",      {24'd0, m_reg[0]}, 32'h00);

      // Random traffic with occasional resets
      for (int c = 0; c < 500; c++) begin
         instr_valid = $urandom_range(0, 1);
         instr       = 8'($urandom);
         ld_en       = ($urandom_range(0, 3) == 0);
         ld_addr     = 2'($urandom);
         ld_data     = 8'($urandom);
         rst_n       = ($urandom_range(0, 99) != 0);
         tick();
      end
      instr_valid = 1'b0; ld_en = 1'b0; rst_n = 1'b1;
      repeat (8) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
